adder_arbiter: RTL and testbench

//  Shares one registered W-bit adder among NREQ requesters. Round-robin arbitration,
//  one operation in flight. Owns the adder operand inputs, samples the adder

---
 rtl/adder_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_adder_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// ============================================================================
// adder_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Shares one registered W-bit adder among NREQ requesters. A round-robin
//   arbiter grants one requester at a time. The block keeps a single
//   operation in flight. It drives the adder operand registers, samples the
//   adder result once the adder latency has elapsed, and returns the sum
//   tagged with the id of the requester that issued it.
//
// Optional feature (compile-time macro):
//   ADDARB_CARRY_EN - when defined, adds output port rsp_carry. It holds the
//                     unsigned carry-out of the returned sum, detected as
//                     (add_c < captured add_a). When undefined, the port and
//                     its logic are absent.
//
// Parameters:
//   W        operand / result width
//   NREQ     number of requesters (>= 2)
//   IDW      requester id width, clog2(NREQ)
//   ADD_LAT  adder latency in clocks, operands in -> add_c valid (>= 1)
//
// Ports:
//   clk        in   1        clock, rising edge
//   reset      in   1        asynchronous, active-low (0 = reset)
//   req_valid  in   NREQ     requester i has operands ready
//   req_a      in   NREQ*W   operand a, requester i at [i*W +: W]
//   req_b      in   NREQ*W   operand b, same packing
//   req_ready  out  NREQ     one-hot accept (combinational)
//   add_a      out  W        registered operand a to the adder
//   add_b      out  W        registered operand b to the adder
//   add_c      in   W        result from the adder
//   rsp_valid  out  1        response valid, held until accepted
//   rsp_id     out  IDW      requester index of this response
//   rsp_sum    out  W        (a + b) mod 2^W
//   rsp_ready  in   1        consumer accepts the response
//   busy       out  1        high in any state other than IDLE
//   rsp_carry  out  1        carry-out of rsp_sum (ADDARB_CARRY_EN only)
// ============================================================================
module adder_arbiter #(
    parameter int W       = 8,
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int ADD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    input  logic [W-1:0]      add_c,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_sum,
    input  logic              rsp_ready,
`ifdef ADDARB_CARRY_EN
    output logic              busy,
    output logic              rsp_carry
`else
    output logic              busy
`endif
);

    // The wait counter is loaded with ADD_LAT and counts down to zero, so
    // the WAIT state lasts ADD_LAT+1 cycles. That gives the adder its full
    // latency after add_a/add_b become valid, and then one more cycle so
    // that add_c is stable when it is sampled.
    localparam int             CNTW     = (ADD_LAT < 1) ? 1 : $clog2(ADD_LAT + 1);
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(ADD_LAT);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Registered state
    state_t          state_q,     state_d;
    logic [IDW-1:0]  rr_ptr_q,    rr_ptr_d;
    logic [IDW-1:0]  tag_q,       tag_d;
    logic [CNTW-1:0] cnt_q,       cnt_d;
    logic [W-1:0]    add_a_q,     add_a_d;
    logic [W-1:0]    add_b_q,     add_b_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q,    rsp_id_d;
    logic [W-1:0]    rsp_sum_q,   rsp_sum_d;
`ifdef ADDARB_CARRY_EN
    logic            rsp_carry_q, rsp_carry_d;
`endif

    // Arbiter results
    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic            grant_take;

    // Index (base + offset) on the ring of requesters. NREQ does not have
    // to be a power of two, so the wrap is done explicitly. The offset is
    // always below NREQ, so a single subtraction is enough.
    function automatic logic [IDW-1:0] ring_idx(input logic [IDW-1:0] base,
                                                input int             offset);
        int pos;
        pos = int'(base) + offset;
        if (pos >= NREQ) begin
            pos = pos - NREQ;
        end
        return pos[IDW-1:0];
    endfunction

    // Round-robin search. The search starts at rr_ptr and walks the ring,
    // and the first active request wins. Nothing here is stateful. If a
    // request drops before the grant edge, it only withdraws the grant.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && req_valid[ring_idx(rr_ptr_q, k)]) begin
                grant_found = 1'b1;
                grant_idx   = ring_idx(rr_ptr_q, k);
            end
        end
    end

    // A grant is offered only in IDLE and only while reset is released.
    // req_ready is combinational, so it must be forced low during reset.
    assign grant_take = (state_q == ST_IDLE) && grant_found && reset;

    always_comb begin
        req_ready = '0;
        if (grant_take) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Next-state logic. Every register holds by default. Operands are
    // captured only on the grant edge. The result is captured only on the
    // last WAIT edge. The response is dropped only on the rsp_valid &&
    // rsp_ready handshake.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        tag_d       = tag_q;
        cnt_d       = cnt_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
`ifdef ADDARB_CARRY_EN
        rsp_carry_d = rsp_carry_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (grant_take) begin
                    add_a_d  = req_a[grant_idx*W +: W];
                    add_b_d  = req_b[grant_idx*W +: W];
                    tag_d    = grant_idx;
                    rr_ptr_d = ring_idx(grant_idx, 1);
                    cnt_d    = CNT_LOAD;
                    state_d  = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_sum_d   = add_c;
                    rsp_id_d    = tag_q;
                    rsp_valid_d = 1'b1;
`ifdef ADDARB_CARRY_EN
                    // The adder output wraps below operand a exactly
                    // when the unsigned sum overflowed.
                    rsp_carry_d = (add_c < add_a_q);
`endif
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Single state register for the FSM and all of its registered outputs.
    // An asynchronous reset discards any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            tag_q       <= '0;
            cnt_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
`ifdef ADDARB_CARRY_EN
            rsp_carry_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            tag_q       <= tag_d;
            cnt_q       <= cnt_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
`ifdef ADDARB_CARRY_EN
            rsp_carry_q <= rsp_carry_d;
`endif
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign busy      = (state_q != ST_IDLE);
`ifdef ADDARB_CARRY_EN
    assign rsp_carry = rsp_carry_q;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// ============================================================================
// tb_adder_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for adder_arbiter with default parameters (W=8,
// NREQ=4, ADD_LAT=1). A registered one-cycle adder model closes the adder
// loop. Inputs are driven on the falling edge, and outputs are sampled 1 ns
// later. Single-request operations come from a vector table. Round-robin
// order, a stalled response, and a reset in mid-operation are written as
// hand-made sequences.
// ============================================================================
module tb_adder_arbiter;

    logic        clk;
    logic        resetN;
    logic [3:0]  reqValid;
    logic [31:0] reqA;
    logic [31:0] reqB;
    logic [3:0]  reqReady;
    logic [7:0]  addA;
    logic [7:0]  addB;
    logic [7:0]  addC;
    logic        rspValid;
    logic [1:0]  rspId;
    logic [7:0]  rspSum;
    logic        rspReady;
    logic        busy;
`ifdef ADDARB_CARRY_EN
    logic        rspCarry;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] expSum;
        logic       expCarry;
    } opVec_t;

    opVec_t vecs[7];

    adder_arbiter #(.W(8), .NREQ(4), .IDW(2), .ADD_LAT(1)) dut (
        .clk       (clk),
        .reset     (resetN),
        .req_valid (reqValid),
        .req_a     (reqA),
        .req_b     (reqB),
        .req_ready (reqReady),
        .add_a     (addA),
        .add_b     (addB),
        .add_c     (addC),
        .rsp_valid (rspValid),
        .rsp_id    (rspId),
        .rsp_sum   (rspSum),
        .rsp_ready (rspReady),
`ifdef ADDARB_CARRY_EN
        .busy      (busy),
        .rsp_carry (rspCarry)
`else
        .busy      (busy)
`endif
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered adder with one cycle of latency and no reset
    always_ff @(posedge clk) addC <= addA + addB;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int ohIdx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic setOperand(input int id, input logic [7:0] a, input logic [7:0] b);
        reqA[id*8 +: 8] = a;
        reqB[id*8 +: 8] = b;
    endtask

    task automatic resetDut();
        @(negedge clk);
        resetN   = 1'b0;
        reqValid = 4'b0000;
        rspReady = 1'b1;
        reqA     = '0;
        reqB     = '0;
        repeat (3) @(negedge clk);
        resetN = 1'b1;
    endtask

    // Wait with a bound until the block is idle again
    task automatic drainIdle(input string name);
        int n;
        n = 0;
        #1;
        while (busy && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput({name, " drain"}, 32'(busy), 32'd0);
    endtask

    // One operation from a single requester, with rsp_ready held high
    task automatic applyStimulus(input opVec_t v);
        int cyc;
        int lat;
        @(negedge clk);
        reqA     = 32'hEEEE_EEEE;
        reqB     = 32'hEEEE_EEEE;
        setOperand(v.id, v.a, v.b);
        reqValid = 4'b0001 << v.id;
        rspReady = 1'b1;
        #1;
        cyc = 0;
        while (reqReady == 4'b0000 && cyc < 20) begin
            @(negedge clk); #1;
            cyc++;
        end
        checkOutput($sformatf("vec id%0d req_ready", v.id), 32'(reqReady), 32'(4'b0001 << v.id));
        // Past the grant edge: change operands to prove they were captured
        @(negedge clk);
        reqValid = 4'b0000;
        setOperand(v.id, ~v.a, ~v.b);
        #1;
        checkOutput("busy in wait", 32'(busy), 32'd1);
        checkOutput("add_a captured", 32'(addA), 32'(v.a));
        checkOutput("add_b captured", 32'(addB), 32'(v.b));
        lat = 1;
        while (!rspValid && lat < 20) begin
            @(negedge clk); #1;
            lat++;
        end
        checkOutput("latency", lat, 32'd3);
        checkOutput($sformatf("sum %0d+%0d", v.a, v.b), 32'(rspSum), 32'(v.expSum));
        checkOutput("rsp_id", 32'(rspId), 32'(v.id));
`ifdef ADDARB_CARRY_EN
        checkOutput($sformatf("carry %0d+%0d", v.a, v.b), 32'(rspCarry), 32'(v.expCarry));
`endif
        @(negedge clk); #1;
        checkOutput("rsp consumed", 32'(rspValid), 32'd0);
        checkOutput("busy after rsp", 32'(busy), 32'd0);
    endtask

    initial begin
        int gIdx[$];
        int gCyc[$];
        int sums[$];
        int ids[$];
        int n;
        int hits;

        resetN   = 1'b0;
        reqValid = 4'b1111;
        reqA     = 32'h0302_0100;
        reqB     = 32'h0A0A_0A0A;
        rspReady = 1'b1;

        vecs[0] = '{0, 8'd4,   8'd7,   8'd11,  1'b0};
        vecs[1] = '{0, 8'd200, 8'd100, 8'd44,  1'b1};
        vecs[2] = '{0, 8'd8,   8'd17,  8'd25,  1'b0};
        vecs[3] = '{3, 8'd255, 8'd1,   8'd0,   1'b1};
        vecs[4] = '{2, 8'd128, 8'd128, 8'd0,   1'b1};
        vecs[5] = '{1, 8'd0,   8'd0,   8'd0,   1'b0};
        vecs[6] = '{1, 8'd255, 8'd0,   8'd255, 1'b0};

        // Reset values, with requests pending during reset
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset req_ready", 32'(reqReady), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset rsp_valid", 32'(rspValid), 32'd0);
        checkOutput("reset rsp_id", 32'(rspId), 32'd0);
        checkOutput("reset rsp_sum", 32'(rspSum), 32'd0);
        checkOutput("reset add_a", 32'(addA), 32'd0);
        checkOutput("reset add_b", 32'(addB), 32'd0);
        resetDut();

        // Table-driven single operations
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
        end

        // Round robin with all four requesters active: ai=i, bi=10
        resetDut();
        @(negedge clk);
        reqA     = 32'h0302_0100;
        reqB     = 32'h0A0A_0A0A;
        reqValid = 4'b1111;
        for (int c = 0; c < 24; c++) begin
            #1;
            if (reqReady != 4'b0000) begin
                gIdx.push_back(ohIdx(reqReady));
                gCyc.push_back(c);
            end
            if (rspValid) begin
                sums.push_back(int'(rspSum));
                ids.push_back(int'(rspId));
            end
            @(negedge clk);
        end
        reqValid = 4'b0000;
        drainIdle("rr");
        checkOutput("rr grant count>=5", 32'(gIdx.size() >= 5), 32'd1);
        checkOutput("rr rsp count>=5", 32'(sums.size() >= 5), 32'd1);
        for (int i = 0; i < 5 && i < gIdx.size(); i++) begin
            checkOutput($sformatf("rr grant %0d", i), gIdx[i], i % 4);
            if (i > 0) checkOutput($sformatf("rr spacing %0d", i), gCyc[i] - gCyc[i-1], 32'd4);
        end
        for (int i = 0; i < 5 && i < sums.size(); i++) begin
            checkOutput($sformatf("rr sum %0d", i), sums[i], 10 + (i % 4));
            checkOutput($sformatf("rr id %0d", i), ids[i], i % 4);
        end

        // Response held while rsp_ready is low; no grant until after handshake
        resetDut();
        @(negedge clk);
        rspReady = 1'b0;
        setOperand(2, 8'd50, 8'd60);
        reqValid = 4'b0100;
        #1;
        n = 0;
        while (reqReady == 4'b0000 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput("stall grant", 32'(reqReady), 32'(4'b0100));
        @(negedge clk);
        reqValid = 4'b1111;
        #1;
        n = 0;
        while (!rspValid && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("stall rsp_valid %0d", k), 32'(rspValid), 32'd1);
            checkOutput($sformatf("stall rsp_sum %0d", k), 32'(rspSum), 32'd110);
            checkOutput($sformatf("stall rsp_id %0d", k), 32'(rspId), 32'd2);
            checkOutput($sformatf("stall req_ready %0d", k), 32'(reqReady), 32'd0);
            @(negedge clk); #1;
        end
        @(negedge clk);
        rspReady = 1'b1;
        #1;
        checkOutput("handshake cycle req_ready", 32'(reqReady), 32'd0);
        @(negedge clk); #1;
        checkOutput("stall consumed", 32'(rspValid), 32'd0);
        checkOutput("post-handshake grant", 32'(reqReady), 32'(4'b1000));
        // Withdraw the offered grant before its edge; rr_ptr must stay at 3
        reqValid = 4'b0000;
        @(negedge clk);
        reqValid = 4'b1001;
        #1;
        checkOutput("withdrawn grant keeps ptr", 32'(reqReady), 32'(4'b1000));
        reqValid = 4'b0000;
        #1;
        checkOutput("withdrawn idle", 32'(busy), 32'd0);

        // Pointer at 2 after granting requester 1: 0110 grants 2, then 1
        resetDut();
        applyStimulus('{1, 8'd5, 8'd6, 8'd11, 1'b0});
        @(negedge clk);
        setOperand(1, 8'd1, 8'd1);
        setOperand(2, 8'd2, 8'd2);
        reqValid = 4'b0110;
        gIdx.delete(); gCyc.delete(); sums.delete();
        for (int c = 0; c < 10; c++) begin
            #1;
            if (reqReady != 4'b0000) begin
                gIdx.push_back(ohIdx(reqReady));
                gCyc.push_back(c);
            end
            if (rspValid) sums.push_back(int'(rspSum));
            @(negedge clk);
        end
        reqValid = 4'b0000;
        drainIdle("ptr2");
        checkOutput("ptr2 grant count>=2", 32'(gIdx.size() >= 2), 32'd1);
        checkOutput("ptr2 rsp count>=2", 32'(sums.size() >= 2), 32'd1);
        if (gIdx.size() >= 2) begin
            checkOutput("ptr2 first grant", gIdx[0], 32'd2);
            checkOutput("ptr2 second grant", gIdx[1], 32'd1);
        end
        if (sums.size() >= 2) begin
            checkOutput("ptr2 first sum", sums[0], 32'd4);
            checkOutput("ptr2 second sum", sums[1], 32'd2);
        end

        // Reset in the middle of WAIT discards the operation
        resetDut();
        @(negedge clk);
        setOperand(0, 8'd9, 8'd9);
        reqValid = 4'b0001;
        #1;
        n = 0;
        while (reqReady == 4'b0000 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput("midreset grant", 32'(reqReady), 32'(4'b0001));
        @(negedge clk);
        reqValid = 4'b0000;
        #1;
        checkOutput("midreset in wait", 32'(busy), 32'd1);
        resetN   = 1'b0;
        reqValid = 4'b1111;
        #1;
        checkOutput("midreset busy", 32'(busy), 32'd0);
        checkOutput("midreset rsp_valid", 32'(rspValid), 32'd0);
        checkOutput("midreset add_a", 32'(addA), 32'd0);
        checkOutput("midreset add_b", 32'(addB), 32'd0);
        checkOutput("midreset req_ready", 32'(reqReady), 32'd0);
        @(negedge clk);
        reqValid = 4'b0000;
        resetN   = 1'b1;
        hits = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (rspValid) hits++;
        end
        checkOutput("no rsp after reset", hits, 32'd0);
        checkOutput("idle after reset", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
